// File: rtl/audio_sampler_if.sv
// Sample-path bundle between the ADC front end and the audio sampler.
// The sampler is the slave: it consumes mic codes and produces strobed audio.
interface audio_sampler_if;
    logic        [11:0] mic_in;
    logic               mic_valid_in;
    logic signed [7:0]  audio_out;
    logic               audio_valid_out;

    modport master (
        output mic_in,
        output mic_valid_in,
        input  audio_out,
        input  audio_valid_out
    );

    modport slave (
        input  mic_in,
        input  mic_valid_in,
        output audio_out,
        output audio_valid_out
    );
endinterface

// File: rtl/audio_sampler.sv
// Decimating microphone sampler with gain/saturation and a debounced
// record-button FSM that counts strobes into a bounded downstream buffer.
//
// state | meaning
// IDLE  | not recording; sample count holds its last value
// REC   | record_out high; each audio strobe bumps the sample count
// FULL  | buffer filled to MAX_SAMPLES; wait for button release
module audio_sampler #(
    parameter int CYCLES_PER_SAMPLE = 8333,
    parameter int MAX_SAMPLES       = 18000,
    parameter int GAIN_SHIFT        = 2,
    parameter int DEBOUNCE_CYCLES   = 1000000
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    audio_sampler_if.slave bus,
    input  logic          record_btn_in,
    output logic          record_out,
    output logic          full_out,
    output logic [15:0]   sample_count_out
);

    localparam int PW = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SHIFT = 4 - GAIN_SHIFT;
    localparam logic [PW-1:0] PERIOD_LAST = PW'(CYCLES_PER_SAMPLE - 1);
    localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]   MAX_COUNT   = 16'(MAX_SAMPLES);

    typedef enum logic [1:0] {IDLE, REC, FULL} state_t;

    logic        [11:0]   hold;
    logic        [PW-1:0] period_cnt;
    logic                 terminal;
    logic        [11:0]   sample_src;
    logic signed [12:0]   centered;
    logic signed [12:0]   scaled;
    logic signed [7:0]    saturated;
    logic signed [7:0]    audio;
    logic                 audio_valid;

    logic                 btn_meta;
    logic                 btn_sync;
    logic                 deb_level;
    logic        [DW-1:0] deb_cnt;
    logic                 deb_differs;
    logic                 deb_done;
    logic                 deb_rise;
    logic                 deb_fall;

    state_t               state;
    state_t               state_next;
    logic        [15:0]   count;
    logic        [15:0]   count_next;

    // Sample datapath: the terminal cycle's own valid code bypasses the hold register
    assign terminal   = (period_cnt == PERIOD_LAST);
    assign sample_src = bus.mic_valid_in ? bus.mic_in : hold;
    assign centered   = $signed({1'b0, sample_src}) - 13'sd2048;
    assign scaled     = centered >>> SHIFT;

    always_comb begin
        saturated = scaled[7:0];
        if (scaled > 13'sd127) begin
            saturated = 8'sd127;
        end else if (scaled < -13'sd128) begin
            saturated = -8'sd128;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hold        <= 12'd2048;
            period_cnt  <= '0;
            audio       <= '0;
            audio_valid <= 1'b0;
        end else begin
            if (bus.mic_valid_in) begin
                hold <= bus.mic_in;
            end
            period_cnt  <= terminal ? '0 : period_cnt + PW'(1);
            audio_valid <= terminal;
            if (terminal) begin
                audio <= saturated;
            end
        end
    end

    assign bus.audio_out       = audio;
    assign bus.audio_valid_out = audio_valid;

    // Button: two-flop synchronizer, then a level that only moves after
    // DEBOUNCE_CYCLES consecutive disagreeing cycles
    assign deb_differs = (btn_sync != deb_level);
    assign deb_done    = deb_differs && (deb_cnt == DEB_LAST);
    assign deb_rise    = deb_done && btn_sync;
    assign deb_fall    = deb_done && !btn_sync;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            btn_meta  <= 1'b0;
            btn_sync  <= 1'b0;
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            btn_meta <= record_btn_in;
            btn_sync <= btn_meta;
            if (!deb_differs) begin
                deb_cnt <= '0;
            end else if (deb_done) begin
                deb_cnt   <= '0;
                deb_level <= btn_sync;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A release coinciding with the final strobe wins: the strobe is counted
    // but the FSM returns to IDLE rather than FULL
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            IDLE: begin
                if (deb_rise) begin
                    state_next = REC;
                    count_next = '0;
                end
            end
            REC: begin
                if (audio_valid && (count < MAX_COUNT)) begin
                    count_next = count + 16'd1;
                end
                if (deb_fall) begin
                    state_next = IDLE;
                end else if (audio_valid && (count_next == MAX_COUNT)) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (deb_fall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign record_out       = (state == REC);
    assign full_out         = (state == FULL);
    assign sample_count_out = count;

endmodule

// File: tb/tb_audio_sampler.sv
// Self-checking bench for audio_sampler: one long-period instance for strobe
// timing/reset, one short-period instance for scaling, debounce and full/stop.
module tb_audio_sampler;

    localparam int CPS_A = 8333;
    localparam int CPS_B = 50;
    localparam int MAX_B = 5;
    localparam int DEB   = 100;
    localparam int GS    = 2;

    logic        clk = 1'b0;
    logic        rst_n_a, rst_n_b;
    logic        btn_a, btn_b;
    logic        rec_a, rec_b, full_a, full_b;
    logic [15:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    audio_sampler_if bus_a ();
    audio_sampler_if bus_b ();

    audio_sampler #(
        .CYCLES_PER_SAMPLE(CPS_A),
        .MAX_SAMPLES(18000),
        .GAIN_SHIFT(GS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut_a (
        .clk_in(clk),
        .rst_n_in(rst_n_a),
        .bus(bus_a.slave),
        .record_btn_in(btn_a),
        .record_out(rec_a),
        .full_out(full_a),
        .sample_count_out(cnt_a)
    );

    audio_sampler #(
        .CYCLES_PER_SAMPLE(CPS_B),
        .MAX_SAMPLES(MAX_B),
        .GAIN_SHIFT(GS),
        .DEBOUNCE_CYCLES(DEB)
    ) dut_b (
        .clk_in(clk),
        .rst_n_in(rst_n_b),
        .bus(bus_b.slave),
        .record_btn_in(btn_b),
        .record_out(rec_b),
        .full_out(full_b),
        .sample_count_out(cnt_b)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Reference scaling: centre, divide by 2^(4-GS) rounding toward -inf, clamp
    function automatic int scale(input int mic);
        int v, d, q;
        v = mic - 2048;
        d = 1 << (4 - GS);
        if (v >= 0) q = v / d;
        else        q = -((-v + d - 1) / d);
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return q;
    endfunction

    initial begin
        int vals [5];
        int tbl  [5];
        int aexp [3];
        int last, exp_audio, t, strobes, next_exp, first, first_rise;
        int k1, k5, rel;
        bit flag;

        vals = '{4095, 0, 2048, 2088, 2007};
        tbl  = '{127, -128, 0, 10, -11};
        aexp = '{10, 13, 127};

        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        btn_a   = 1'b0;
        btn_b   = 1'b0;
        bus_a.mic_in = '0;  bus_a.mic_valid_in = 1'b0;
        bus_b.mic_in = '0;  bus_b.mic_valid_in = 1'b0;
        #1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        #2;
        chk("rst_audio_b", bus_b.audio_out, 0);
        chk("rst_valid_b", bus_b.audio_valid_out, 0);
        chk("rst_rec_b", rec_b, 0);
        chk("rst_full_b", full_b, 0);
        chk("rst_count_b", cnt_b, 0);
        chk("rst_audio_a", bus_a.audio_out, 0);
        chk("rst_count_a", cnt_a, 0);

        // Scaling and strobe cadence under random mic traffic
        @(negedge clk);
        rst_n_b = 1'b1;
        edge_n = 0;
        last = 2048;
        exp_audio = 0;
        for (int p = 0; p < 30; p++) begin
            for (int c = 0; c < CPS_B; c++) begin
                if (p == 0) begin
                    bus_b.mic_valid_in = 1'b0;
                    bus_b.mic_in = 12'($urandom_range(0, 4095));
                end else if (p <= 5) begin
                    bus_b.mic_valid_in = 1'b1;
                    bus_b.mic_in = 12'(vals[p-1]);
                end else begin
                    bus_b.mic_valid_in = ($urandom_range(0, 3) == 0);
                    bus_b.mic_in = 12'($urandom_range(0, 4095));
                end
                if (bus_b.mic_valid_in) last = int'(bus_b.mic_in);
                tick();
                if (edge_n % CPS_B == 0) exp_audio = scale(last);
                chk("b_valid", bus_b.audio_valid_out, (edge_n % CPS_B == 0));
                chk("b_audio", bus_b.audio_out, exp_audio);
                if (p >= 1 && p <= 5 && c == CPS_B - 1)
                    chk("b_scale_tbl", bus_b.audio_out, tbl[p-1]);
            end
        end
        bus_b.mic_valid_in = 1'b0;

        // Bouncing button, then hold through a full recording
        @(negedge clk);
        rst_n_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        edge_n = 0;
        flag = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_b = 1'b1;
            repeat (50) begin tick(); if (rec_b) flag = 1'b1; end
            btn_b = 1'b0;
            repeat (50) begin tick(); if (rec_b) flag = 1'b1; end
        end
        chk("b_no_early_rec", flag, 0);
        btn_b = 1'b1;
        t = 0;
        while (!rec_b && t < 400) begin tick(); t++; end
        chk("b_deb_latency", t, DEB + 2);
        strobes = bus_b.audio_valid_out ? 1 : 0;
        t = 0;
        while (strobes < MAX_B && t < 2000) begin
            tick();
            t++;
            if (bus_b.audio_valid_out) begin
                strobes++;
                chk("b_rec_during_strobe", rec_b, 1);
            end
        end
        chk("b_strobes_recorded", strobes, MAX_B);
        tick();
        chk("b_rec_after_full", rec_b, 0);
        chk("b_full", full_b, 1);
        chk("b_count_full", cnt_b, MAX_B);
        repeat (2 * CPS_B) tick();
        chk("b_count_hold", cnt_b, MAX_B);
        chk("b_full_hold", full_b, 1);
        btn_b = 1'b0;
        repeat (DEB + 1) tick();
        chk("b_full_before_release", full_b, 1);
        tick();
        chk("b_full_cleared", full_b, 0);
        chk("b_count_after_release", cnt_b, MAX_B);
        chk("b_rec_after_release", rec_b, 0);

        // Release qualifies exactly on the edge that counts the last strobe
        @(negedge clk);
        rst_n_b = 1'b0;
        @(negedge clk);
        rst_n_b = 1'b1;
        edge_n = 0;
        btn_b = 1'b1;
        k1  = ((DEB + 2 + CPS_B - 1) / CPS_B) * CPS_B;
        k5  = k1 + (MAX_B - 1) * CPS_B;
        rel = k5 - DEB;
        flag = 1'b0;
        while (edge_n < k5 + 3) begin
            if (edge_n == rel - 1) btn_b = 1'b0;
            tick();
            if (full_b) flag = 1'b1;
            if (edge_n == k5) begin
                chk("c_rec_at_last", rec_b, 1);
                chk("c_valid_at_last", bus_b.audio_valid_out, 1);
                chk("c_count_before", cnt_b, MAX_B - 1);
            end
            if (edge_n == k5 + 1) begin
                chk("c_rec_after", rec_b, 0);
                chk("c_count_after", cnt_b, MAX_B);
            end
        end
        chk("c_full_never", flag, 0);
        chk("c_count_end", cnt_b, MAX_B);

        // Long period: strobe timing, bypass, then reset mid-recording
        @(negedge clk);
        rst_n_a = 1'b1;
        edge_n = 0;
        btn_a = 1'b1;
        strobes = 0;
        next_exp = CPS_A;
        first_rise = 0;
        while (edge_n < 3 * CPS_A + 1) begin
            if (edge_n + 1 == 1) begin
                bus_a.mic_in = 12'd2088; bus_a.mic_valid_in = 1'b1;
            end else if (edge_n + 1 == 2 * CPS_A) begin
                bus_a.mic_in = 12'd2100; bus_a.mic_valid_in = 1'b1;
            end else if (edge_n + 1 == 2 * CPS_A + CPS_A / 2) begin
                bus_a.mic_in = 12'd4095; bus_a.mic_valid_in = 1'b1;
            end else begin
                bus_a.mic_in = 12'($urandom_range(0, 4095)); bus_a.mic_valid_in = 1'b0;
            end
            tick();
            if (rec_a && first_rise == 0) first_rise = edge_n;
            if (bus_a.audio_valid_out) begin
                chk("a_strobe_edge", edge_n, next_exp);
                if (strobes < 3) chk("a_strobe_value", bus_a.audio_out, aexp[strobes]);
                strobes++;
                next_exp += CPS_A;
            end
        end
        bus_a.mic_valid_in = 1'b0;
        chk("a_strobe_count", strobes, 3);
        chk("a_rec_rise", first_rise, DEB + 2);
        chk("a_count3", cnt_a, 3);
        chk("a_rec_before_reset", rec_a, 1);
        #2;
        rst_n_a = 1'b0;
        #1;
        chk("a_rst_rec", rec_a, 0);
        chk("a_rst_count", cnt_a, 0);
        chk("a_rst_audio", bus_a.audio_out, 0);
        chk("a_rst_valid", bus_a.audio_valid_out, 0);
        flag = 1'b0;
        repeat (3) begin tick(); if (bus_a.audio_valid_out) flag = 1'b1; end
        chk("a_no_strobe_in_reset", flag, 0);
        @(negedge clk);
        rst_n_a = 1'b1;
        edge_n = 0;
        first = 0;
        first_rise = 0;
        while (edge_n < CPS_A + 2) begin
            tick();
            if (bus_a.audio_valid_out && first == 0) first = edge_n;
            if (rec_a && first_rise == 0) first_rise = edge_n;
        end
        chk("a_first_strobe_after_reset", first, CPS_A);
        chk("a_rerecord_after_reset", first_rise, DEB + 2);
        chk("a_count_restart", cnt_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
